// File: rtl/miriscv_lsu_if.sv
// Data-port bus between the load-store unit and the shared instruction/data RAM.
interface miriscv_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o,
    output data_we_o,
    output data_be_o,
    output data_addr_o,
    output data_wdata_o,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_o,
    input  data_we_o,
    input  data_be_o,
    input  data_addr_o,
    input  data_wdata_o,
    output data_rdata_i
  );
endinterface

// File: rtl/miriscv_lsu.sv
// Load-store unit: alignment check, byte-lane formatting of RAM accesses, stall for
// the RAM read latency and sign/zero extension of returned load data.
module miriscv_lsu #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lsu_req_i,
  input  logic          lsu_we_i,
  input  logic [2:0]    lsu_size_i,
  input  logic [31:0]   lsu_addr_i,
  input  logic [31:0]   lsu_data_i,
  output logic [31:0]   lsu_data_o,
  output logic          lsu_stall_req_o,
  output logic          lsu_misalign_o,
  miriscv_lsu_if.master data_if
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [1:0] LAT_CNT = 2'(RAM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;

  logic        illegal;
  logic        accept;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_data;

  always_comb begin
    illegal = 1'b0;
    case (lsu_size_i)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = lsu_addr_i[0];
      3'd2:    illegal = |lsu_addr_i[1:0];
      3'd4:    illegal = lsu_we_i;
      3'd5:    illegal = lsu_we_i | lsu_addr_i[0];
      default: illegal = 1'b1;
    endcase
  end

  assign accept = (state_q == IDLE) && lsu_req_i && !illegal;

  always_comb begin
    rd_shift = data_if.data_rdata_i >> {off_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = off_q[1] ? data_if.data_rdata_i[31:16] : data_if.data_rdata_i[15:0];
    case (size_q)
      3'd0:    ext_data = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    ext_data = {24'd0, rd_byte};
      3'd1:    ext_data = {{16{rd_half[15]}}, rd_half};
      3'd5:    ext_data = {16'd0, rd_half};
      default: ext_data = data_if.data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = LAT_CNT;
          off_d   = lsu_addr_i[1:0];
          size_d  = lsu_size_i;
          we_d    = lsu_we_i;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = IDLE;
          if (!we_q) rdata_d = ext_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to their reset values while rst_i is high so a held
  // request cannot reach the RAM during the reset cycle.
  always_comb begin
    lsu_data_o           = rdata_q;
    lsu_stall_req_o      = 1'b0;
    lsu_misalign_o       = 1'b0;
    data_if.data_req_o   = 1'b0;
    data_if.data_we_o    = 1'b0;
    data_if.data_be_o    = '0;
    data_if.data_addr_o  = '0;
    data_if.data_wdata_o = '0;
    if (rst_i) begin
      lsu_data_o = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_req_i && illegal) begin
            lsu_misalign_o = 1'b1;
          end else if (accept) begin
            lsu_stall_req_o     = 1'b1;
            data_if.data_req_o  = 1'b1;
            data_if.data_we_o   = lsu_we_i;
            data_if.data_addr_o = {lsu_addr_i[31:2], 2'b00};
            case (lsu_size_i[1:0])
              2'd0: begin
                data_if.data_be_o    = 4'b0001 << lsu_addr_i[1:0];
                data_if.data_wdata_o = {4{lsu_data_i[7:0]}};
              end
              2'd1: begin
                data_if.data_be_o    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                data_if.data_wdata_o = {2{lsu_data_i[15:0]}};
              end
              default: begin
                data_if.data_be_o    = 4'b1111;
                data_if.data_wdata_o = lsu_data_i;
              end
            endcase
          end
        end
        WAIT: begin
          lsu_stall_req_o = (cnt_q != 2'd0);
          if (cnt_q == 2'd0 && !we_q) lsu_data_o = ext_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: latency-1 and latency-3 instances on shared core inputs.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdat;

  logic [31:0] d1_data, d3_data;
  logic        d1_stall, d3_stall, d1_mis, d3_mis;

  miriscv_lsu_if bus1();
  miriscv_lsu_if bus3();

  miriscv_lsu #(.RAM_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size),
    .lsu_addr_i(addr), .lsu_data_i(wdat), .lsu_data_o(d1_data),
    .lsu_stall_req_o(d1_stall), .lsu_misalign_o(d1_mis), .data_if(bus1)
  );

  miriscv_lsu #(.RAM_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size),
    .lsu_addr_i(addr), .lsu_data_i(wdat), .lsu_data_o(d3_data),
    .lsu_stall_req_o(d3_stall), .lsu_misalign_o(d3_mis), .data_if(bus3)
  );

  always #5 clk = ~clk;

  // Behavioural RAMs with byte-enabled writes and 1- or 3-cycle read pipelines
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  assign bus1.data_rdata_i = pipe1;
  assign bus3.data_rdata_i = pipe3[2];

  always @(posedge clk) begin
    if (bus1.data_req_o) begin
      if (bus1.data_we_o) begin
        for (int i = 0; i < 4; i++)
          if (bus1.data_be_o[i]) mem1[bus1.data_addr_o[7:2]][8*i +: 8] <= bus1.data_wdata_o[8*i +: 8];
      end else begin
        pipe1 <= mem1[bus1.data_addr_o[7:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (bus3.data_req_o) begin
      if (bus3.data_we_o) begin
        for (int i = 0; i < 4; i++)
          if (bus3.data_be_o[i]) mem3[bus3.data_addr_o[7:2]][8*i +: 8] <= bus3.data_wdata_o[8*i +: 8];
      end else begin
        pipe3[0] <= mem3[bus3.data_addr_o[7:2]];
      end
    end
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t        vec [0:17];
  logic [31:0] last_load;

  initial begin
    vec[0]  = '{1'b1, 3'd0, 32'h13, 32'h000000A5, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vec[1]  = '{1'b0, 3'd0, 32'h23, 32'h0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80};
    vec[2]  = '{1'b0, 3'd4, 32'h23, 32'h0, 1'b0, 4'b1000, 32'h0, 32'h00000080};
    vec[3]  = '{1'b0, 3'd1, 32'h22, 32'h0, 1'b0, 4'b1100, 32'h0, 32'hFFFF80F1};
    vec[4]  = '{1'b0, 3'd5, 32'h20, 32'h0, 1'b0, 4'b0011, 32'h0, 32'h00007F01};
    vec[5]  = '{1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h80F17F01};
    vec[6]  = '{1'b0, 3'd2, 32'h22, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vec[7]  = '{1'b1, 3'd1, 32'h05, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vec[8]  = '{1'b0, 3'd3, 32'h00, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vec[9]  = '{1'b1, 3'd4, 32'h00, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vec[10] = '{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hA5000000};
    vec[11] = '{1'b1, 3'd1, 32'h22, 32'h1234BEEF, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vec[12] = '{1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hBEEF7F01};
    vec[13] = '{1'b1, 3'd2, 32'h1C, 32'hCAFEF00D, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
    vec[14] = '{1'b0, 3'd0, 32'h1D, 32'h0, 1'b0, 4'b0010, 32'h0, 32'hFFFFFFF0};
    vec[15] = '{1'b0, 3'd5, 32'h1E, 32'h0, 1'b0, 4'b1100, 32'h0, 32'h0000CAFE};
    vec[16] = '{1'b0, 3'd1, 32'h1C, 32'h0, 1'b0, 4'b0011, 32'h0, 32'hFFFFF00D};
    vec[17] = '{1'b0, 3'd4, 32'h1C, 32'h0, 1'b0, 4'b0001, 32'h0, 32'h0000000D};

    for (int i = 0; i < 64; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem1[8]  = 32'h80F17F01; mem3[8]  = 32'h80F17F01;
    mem1[16] = 32'h11112222; mem3[16] = 32'h11112222;
    mem1[17] = 32'h33334444; mem3[17] = 32'h33334444;
    pipe1 = '0;
    for (int i = 0; i < 3; i++) pipe3[i] = '0;

    // Reset held three cycles with a legal request pending
    rst = 1'b1; req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h20; wdat = '0;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_req1", c), {31'd0, bus1.data_req_o}, 32'd0);
      chk($sformatf("rst%0d_req3", c), {31'd0, bus3.data_req_o}, 32'd0);
      chk($sformatf("rst%0d_stall1", c), {31'd0, d1_stall}, 32'd0);
      chk($sformatf("rst%0d_data1", c), d1_data, 32'd0);
      step();
    end
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post_rst_stall1", {31'd0, d1_stall}, 32'd0);
    chk("post_rst_stall3", {31'd0, d3_stall}, 32'd0);
    chk("post_rst_data1", d1_data, 32'd0);
    step();

    // Latency-1 vectors
    last_load = '0;
    for (int i = 0; i < 18; i++) begin
      req = 1'b1; we = vec[i].we; size = vec[i].size; addr = vec[i].addr; wdat = vec[i].data;
      @(negedge clk);
      chk($sformatf("v%0d_misalign", i), {31'd0, d1_mis}, {31'd0, vec[i].mis});
      chk($sformatf("v%0d_req", i), {31'd0, bus1.data_req_o}, {31'd0, !vec[i].mis});
      chk($sformatf("v%0d_stall", i), {31'd0, d1_stall}, {31'd0, !vec[i].mis});
      if (!vec[i].mis) begin
        chk($sformatf("v%0d_we", i), {31'd0, bus1.data_we_o}, {31'd0, vec[i].we});
        chk($sformatf("v%0d_be", i), {28'd0, bus1.data_be_o}, {28'd0, vec[i].be});
        chk($sformatf("v%0d_addr", i), bus1.data_addr_o, {vec[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_wdata", i), bus1.data_wdata_o, vec[i].wdata);
      end
      step();
      req = 1'b0;
      if (!vec[i].mis) begin
        @(negedge clk);
        chk($sformatf("v%0d_wait_req", i), {31'd0, bus1.data_req_o}, 32'd0);
        chk($sformatf("v%0d_wait_stall", i), {31'd0, d1_stall}, 32'd0);
        if (!vec[i].we) begin
          chk($sformatf("v%0d_rdata", i), d1_data, vec[i].rdata);
          last_load = vec[i].rdata;
        end
        step();
      end
      @(negedge clk);
      chk($sformatf("v%0d_hold", i), d1_data, last_load);
      step();
    end

    // Latency-3 back-to-back loads, request held high throughout
    for (int c = 0; c < 4; c++) step();
    req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h40; wdat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("l3_c%0d_req", c), {31'd0, bus3.data_req_o}, {31'd0, (c == 0 || c == 4)});
      chk($sformatf("l3_c%0d_stall", c), {31'd0, d3_stall}, {31'd0, (c != 3 && c != 7)});
      if (c == 4) chk("l3_c4_addr", bus3.data_addr_o, 32'h44);
      if (c == 3) chk("l3_c3_data", d3_data, 32'h11112222);
      if (c == 7) chk("l3_c7_data", d3_data, 32'h33334444);
      step();
      if (c == 3) addr = 32'h44;
    end
    req = 1'b0;
    @(negedge clk);
    chk("l3_hold_data", d3_data, 32'h33334444);
    chk("l3_idle_stall", {31'd0, d3_stall}, 32'd0);
    for (int c = 0; c < 4; c++) step();

    // Reset asserted in WAIT of a load on both instances
    req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h20;
    @(negedge clk);
    chk("rw_issue_req1", {31'd0, bus1.data_req_o}, 32'd1);
    chk("rw_issue_req3", {31'd0, bus3.data_req_o}, 32'd1);
    step();
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("rw_rst_data1", d1_data, 32'd0);
    chk("rw_rst_stall3", {31'd0, d3_stall}, 32'd0);
    chk("rw_rst_data3", d3_data, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_after_req1", {31'd0, bus1.data_req_o}, 32'd0);
    chk("rw_after_data1", d1_data, 32'd0);
    chk("rw_after_stall3", {31'd0, d3_stall}, 32'd0);
    chk("rw_after_req3", {31'd0, bus3.data_req_o}, 32'd0);
    chk("rw_after_data3", d3_data, 32'd0);
    step();
    @(negedge clk);
    chk("rw_idle_stall3", {31'd0, d3_stall}, 32'd0);
    chk("rw_idle_data3", d3_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
